// File: rtl/letter_read_arbiter.sv
// Round-robin arbiter sharing the letter-memory read path among NUMREQ requesters.
// Supports single-letter reads and whole-word bursts; responses are tagged with id/last.
module letter_read_arbiter #(
    parameter int NUMREQ       = 4,
    parameter int ROWINDEXBITS = 8,
    parameter int COLINDEXBITS = 4,
    parameter int LETTERBITS   = 8,
    parameter int READLATENCY  = 2,
    parameter int IDBITS       = 2
) (
    input  logic                                                clock,
    input  logic                                                reset_n,
    input  logic [NUMREQ-1:0]                                   reqValid,
    input  logic [NUMREQ-1:0]                                   reqBurst,
    input  logic [NUMREQ-1:0][ROWINDEXBITS+COLINDEXBITS-1:0]    reqAddress,
    output logic [NUMREQ-1:0]                                   reqReady,
    output logic                                                busy,
    output logic [ROWINDEXBITS+COLINDEXBITS-1:0]                memAddress,
    output logic                                                memAddressValid,
    input  logic [LETTERBITS-1:0]                               memData,
    output logic                                                respValid,
    output logic [LETTERBITS-1:0]                               respData,
    output logic [IDBITS-1:0]                                   respId,
    output logic                                                respLast
);

    localparam int AW = ROWINDEXBITS + COLINDEXBITS;

    typedef enum logic {S_IDLE, S_BURST} state_t;

    typedef struct packed {
        logic              vld;
        logic [IDBITS-1:0] id;
        logic              last;
    } tag_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [IDBITS-1:0]       r_rr;
    logic [COLINDEXBITS-1:0] r_cnt;
    logic [ROWINDEXBITS-1:0] r_word;
    logic [IDBITS-1:0]       r_id;
    tag_t                    r_tag [READLATENCY:0];

    logic                    w_any;
    logic [IDBITS-1:0]       w_win;
    logic [NUMREQ-1:0]       w_grant;
    logic                    w_accept;
    int                      w_idx;

    // First valid requester at or after the round-robin pointer.
    always_comb begin
        w_any   = 1'b0;
        w_win   = '0;
        w_grant = '0;
        w_idx   = 0;
        for (int k = 0; k < NUMREQ; k++) begin
            w_idx = int'(r_rr) + k;
            if (w_idx >= NUMREQ) w_idx = w_idx - NUMREQ;
            if (!w_any && reqValid[w_idx]) begin
                w_any = 1'b1;
                w_win = IDBITS'(w_idx);
            end
        end
        if (w_any) w_grant[w_win] = 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && reqBurst[w_win]) w_state_nxt = S_BURST;
            S_BURST: if (r_cnt == '1) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // reqReady is masked by reset_n so the grant vanishes the moment reset asserts.
    always_comb begin
        reqReady = '0;
        busy     = 1'b0;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_accept = w_any;
                if (reset_n) reqReady = w_grant;
            end
            S_BURST: busy = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rr       <= '0;
            r_cnt      <= '0;
            r_word     <= '0;
            r_id       <= '0;
            memAddress <= '0;
            for (int s = 0; s <= READLATENCY; s++) r_tag[s] <= '0;
        end else begin
            r_tag[0] <= '0;
            for (int s = 1; s <= READLATENCY; s++) r_tag[s] <= r_tag[s-1];
            if (r_state == S_IDLE && w_accept) begin
                r_rr     <= (w_win == IDBITS'(NUMREQ-1)) ? '0 : w_win + IDBITS'(1);
                r_tag[0] <= '{vld: 1'b1, id: w_win, last: !reqBurst[w_win]};
                if (reqBurst[w_win]) begin
                    memAddress <= {reqAddress[w_win][AW-1:COLINDEXBITS], {COLINDEXBITS{1'b0}}};
                    r_word     <= reqAddress[w_win][AW-1:COLINDEXBITS];
                    r_id       <= w_win;
                    r_cnt      <= COLINDEXBITS'(1);
                end else begin
                    memAddress <= reqAddress[w_win];
                end
            end else if (r_state == S_BURST) begin
                memAddress <= {r_word, r_cnt};
                r_tag[0]   <= '{vld: 1'b1, id: r_id, last: (r_cnt == '1)};
                r_cnt      <= r_cnt + COLINDEXBITS'(1);
            end
        end
    end

    assign memAddressValid = r_tag[0].vld;
    assign respValid       = r_tag[READLATENCY].vld;
    assign respId          = r_tag[READLATENCY].id;
    assign respLast        = r_tag[READLATENCY].last;
    assign respData        = respValid ? memData : '0;

endmodule

// File: tb/tb_letter_read_arbiter.sv
// Bench for letter_read_arbiter: directed scenarios then random traffic, each cycle
// compared against a cycle-schedule reference model with a behavioural RAM.
module tb_letter_read_arbiter;

    localparam int NR   = 4;
    localparam int RB   = 8;
    localparam int CB   = 4;
    localparam int LB   = 8;
    localparam int RL   = 2;
    localparam int IB   = 2;
    localparam int AW   = RB + CB;
    localparam int BL   = 1 << CB;
    localparam int MAXC = 4096;

    logic                    clock = 1'b0;
    logic                    reset_n;
    logic [NR-1:0]           rv, rb;
    logic [NR-1:0][AW-1:0]   ra;
    logic [NR-1:0]           reqReady;
    logic                    busy;
    logic [AW-1:0]           memAddress;
    logic                    memAddressValid;
    logic [LB-1:0]           memData;
    logic                    respValid;
    logic [LB-1:0]           respData;
    logic [IB-1:0]           respId;
    logic                    respLast;

    always #5 clock = ~clock;

    letter_read_arbiter #(
        .NUMREQ(NR), .ROWINDEXBITS(RB), .COLINDEXBITS(CB),
        .LETTERBITS(LB), .READLATENCY(RL), .IDBITS(IB)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .reqValid(rv), .reqBurst(rb), .reqAddress(ra),
        .reqReady(reqReady), .busy(busy),
        .memAddress(memAddress), .memAddressValid(memAddressValid),
        .memData(memData),
        .respValid(respValid), .respData(respData),
        .respId(respId), .respLast(respLast)
    );

    // Splitter + RAM environment: content is a fixed function of the address.
    function automatic logic [LB-1:0] ram(input logic [AW-1:0] a);
        logic [LB-1:0] m;
        m = a[7:0] * 8'd37;
        return m ^ {a[3:0], a[11:8]} ^ 8'h5A;
    endfunction

    logic [AW-1:0] mp [RL];
    always @(posedge clock) begin
        mp[0] <= memAddress;
        for (int k = 1; k < RL; k++) mp[k] <= mp[k-1];
    end
    assign memData = ram(mp[RL-1]);

    // Reference model: expected memory issues indexed by cycle number.
    int            cyc, n_chk, n_pass;
    bit            iv  [MAXC];
    logic [AW-1:0] ia  [MAXC];
    logic [IB-1:0] iid [MAXC];
    bit            il  [MAXC];
    int            rr, free_at, busy_lo, busy_hi;
    logic [AW-1:0] ma_m;
    logic [NR-1:0] acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    endtask

    task automatic model_reset();
        foreach (iv[k]) iv[k] = 1'b0;
        rr = 0; free_at = 0; busy_lo = 1; busy_hi = 0; ma_m = '0; acc = '0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".reqReady"}, reqReady, 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".memAddressValid"}, memAddressValid, 0);
        chk({tag, ".memAddress"}, memAddress, 0);
        chk({tag, ".respValid"}, respValid, 0);
        chk({tag, ".respData"}, respData, 0);
        chk({tag, ".respId"}, respId, 0);
        chk({tag, ".respLast"}, respLast, 0);
    endtask

    task automatic sched(input int t, input logic [AW-1:0] a, input int id, input bit last);
        iv[t] = 1'b1; ia[t] = a; iid[t] = IB'(id); il[t] = last;
    endtask

    task automatic model_step();
        int c, w;
        logic [NR-1:0] er;
        bit ev;
        c = cyc; w = -1; er = '0; acc = '0;
        if (!reset_n) begin
            check_zero("in_reset");
            return;
        end
        if (iv[c]) ma_m = ia[c];
        if (c >= free_at) begin
            for (int k = 0; k < NR; k++) begin
                int i;
                i = (rr + k) % NR;
                if (w < 0 && rv[i]) w = i;
            end
        end
        if (w >= 0) begin
            er[w] = 1'b1;
            acc   = er;
            rr    = (w + 1) % NR;
            if (rb[w]) begin
                for (int k = 0; k < BL; k++)
                    sched(c + 1 + k, {ra[w][AW-1:CB], CB'(k)}, w, k == BL - 1);
                free_at = c + BL; busy_lo = c + 1; busy_hi = c + BL - 1;
            end else begin
                sched(c + 1, ra[w], w, 1'b1);
                free_at = c + 1;
            end
        end
        chk("reqReady", reqReady, er);
        chk("busy", busy, (c >= busy_lo && c <= busy_hi));
        chk("memAddressValid", memAddressValid, iv[c]);
        chk("memAddress", memAddress, ma_m);
        ev = (c >= RL) && iv[c-RL];
        chk("respValid", respValid, ev);
        if (ev) begin
            chk("respId", respId, iid[c-RL]);
            chk("respLast", respLast, il[c-RL]);
            chk("respData", respData, ram(ia[c-RL]));
        end else begin
            chk("respData_idle", respData, 0);
        end
    endtask

    // Check at negedge, advance to just after the next posedge, retire accepted requests.
    task automatic cycle();
        @(negedge clock);
        model_step();
        @(posedge clock);
        #1;
        cyc++;
        for (int i = 0; i < NR; i++) if (acc[i]) rv[i] = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        rv = '0;
        #1;
        check_zero(tag);
        model_reset();
        repeat (2) cycle();
        reset_n = 1'b1;
    endtask

    initial begin
        rv = '0; rb = '0; ra = '0; reset_n = 1'b0;
        cyc = 0; n_chk = 0; n_pass = 0;
        model_reset();
        @(posedge clock);
        #1;
        do_reset("reset");

        // Single read at 0x3A5
        rv[0] = 1'b1; rb[0] = 1'b0; ra[0] = 12'h3A5;
        repeat (5) cycle();

        // All four requesters continuously valid, single reads
        repeat (6) begin
            for (int i = 0; i < NR; i++)
                if (!rv[i]) begin rv[i] = 1'b1; rb[i] = 1'b0; ra[i] = AW'($urandom); end
            cycle();
        end
        rv = '0;
        repeat (4) cycle();

        // Burst from requester 2, letter field ignored
        rv[2] = 1'b1; rb[2] = 1'b1; ra[2] = 12'h7F9;
        repeat (20) cycle();

        // Bring pointer back to 0, then burst on 1 and single on 3 together
        rv[3] = 1'b1; rb[3] = 1'b0; ra[3] = 12'h123;
        repeat (2) cycle();
        rv[1] = 1'b1; rb[1] = 1'b1; ra[1] = 12'hC4E;
        rv[3] = 1'b1; rb[3] = 1'b0; ra[3] = 12'h456;
        repeat (22) cycle();

        // Withdraw: requester 1 drops before it is granted
        rv[0] = 1'b1; rb[0] = 1'b0; ra[0] = 12'h0AA;
        rv[1] = 1'b1; rb[1] = 1'b0; ra[1] = 12'h0BB;
        cycle();
        rv[1] = 1'b0;
        repeat (4) cycle();

        // Reset while the fifth burst letter is on the bus
        rv[0] = 1'b1; rb[0] = 1'b1; ra[0] = 12'h9E3;
        repeat (5) cycle();
        do_reset("reset_mid_burst");
        rv[2] = 1'b1; rb[2] = 1'b0; ra[2] = 12'h5C7;
        repeat (6) cycle();

        // Random traffic with occasional bursts and withdrawals
        repeat (1500) begin
            for (int i = 0; i < NR; i++) begin
                if (!rv[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        rv[i] = 1'b1;
                        rb[i] = ($urandom_range(0, 7) == 0);
                        ra[i] = AW'($urandom);
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    rv[i] = 1'b0;
                end
            end
            cycle();
        end
        rv = '0;
        repeat (24) cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
